gol_gen_sequencer: RTL

//   Generation controller for the Game-of-Life cell-update datapath. Walks every cell of the grid in

---
 rtl/gol_pkg.sv | 27 ++
 rtl/gol_gen_sequencer_if.sv | 27 ++
 rtl/gol_rule_decode.sv | 18 +
 rtl/gol_gen_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and constants for the Game-of-Life generation sequencer.
// Holds the FSM state encoding, the default B3/S23 rule masks and the rule-word field layout.
package gol_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_REQ,
        ST_WAIT_RSP,
        ST_SWAP
    } state_e;

    localparam int MASK_W = 9;

    localparam logic [MASK_W-1:0] RULE_DEFAULT_BIRTH   = 9'h008;
    localparam logic [MASK_W-1:0] RULE_DEFAULT_SURVIVE = 9'h00C;

    // Rule word layout: birth mask in [8:0], survive mask in [24:16].
    localparam int RULE_BIRTH_LSB   = 0;
    localparam int RULE_SURVIVE_LSB = 16;

    typedef struct packed {
        logic [MASK_W-1:0] birth;
        logic [MASK_W-1:0] survive;
    } rule_masks_t;

endpackage

// File: rtl/gol_gen_sequencer_if.sv
// Cell request/response and back-bank write bus between the sequencer and the update datapath.
// master = sequencer side, slave = datapath plus grid RAM side.
interface gol_gen_sequencer_if #(
    parameter int X_W    = 3,
    parameter int Y_W    = 3,
    parameter int ADDR_W = 6
);
    logic              cell_req_valid;
    logic              cell_req_ready;
    logic [X_W-1:0]    cell_x;
    logic [Y_W-1:0]    cell_y;
    logic              cell_rsp_valid;
    logic              cell_next;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;

    modport master (
        output cell_req_valid, cell_x, cell_y, wr_en, wr_addr, wr_data,
        input  cell_req_ready, cell_rsp_valid, cell_next
    );

    modport slave (
        input  cell_req_valid, cell_x, cell_y, wr_en, wr_addr, wr_data,
        output cell_req_ready, cell_rsp_valid, cell_next
    );
endinterface

// File: rtl/gol_rule_decode.sv
// Combinational rule-word decode into birth/survive masks.
// An all-zero rule word selects classic Conway B3/S23.
module gol_rule_decode
    import gol_pkg::*;
(
    input  logic [31:0] rule_i,
    output rule_masks_t masks_o
);
    always_comb begin
        // NOTE: every output gets a value before any branch so no latch can be inferred.
        masks_o.birth   = rule_i[RULE_BIRTH_LSB +: MASK_W];
        masks_o.survive = rule_i[RULE_SURVIVE_LSB +: MASK_W];
        if (rule_i == '0) begin
            masks_o.birth   = RULE_DEFAULT_BIRTH;
            masks_o.survive = RULE_DEFAULT_SURVIVE;
        end
    end
endmodule

// File: rtl/gol_gen_sequencer.sv
// Game-of-Life generation controller: rasters the grid, issues one datapath request per cell,
// writes each result into the back bank and swaps banks at the end of every generation.
module gol_gen_sequencer
    import gol_pkg::*;
#(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    parameter int ADDR_W = 6,
    parameter int GEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 run,
    input  logic [31:0]          rule,
    output logic [MASK_W-1:0]    birth_mask,
    output logic [MASK_W-1:0]    survive_mask,
    gol_gen_sequencer_if.master  cell_bus,
    output logic                 bank_sel,
    output logic                 busy,
    output logic                 update_done,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 proto_err
);
    localparam int X_W = $clog2(GRID_W);
    localparam int Y_W = $clog2(GRID_H);
    localparam logic [X_W-1:0] X_LAST = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(GRID_H - 1);

    state_e          state_q;
    logic [X_W-1:0]  x_q;
    logic [Y_W-1:0]  y_q;
    rule_masks_t     masks_q;
    rule_masks_t     masks_dec;
    logic            bank_q;
    logic [GEN_W-1:0] gen_q;
    logic            err_q;
    logic            rsp_accept;

    gol_rule_decode u_rule_decode (
        .rule_i  (rule),
        .masks_o (masks_dec)
    );

    assign rsp_accept = (state_q == ST_WAIT_RSP) && cell_bus.cell_rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            masks_q <= '0;
            bank_q  <= 1'b0;
            gen_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (cell_bus.cell_rsp_valid && state_q != ST_WAIT_RSP) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start || run) state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    masks_q <= masks_dec;
                    x_q     <= '0;
                    y_q     <= '0;
                    state_q <= ST_REQ;
                end
                ST_REQ: begin
                    if (cell_bus.cell_req_ready) state_q <= ST_WAIT_RSP;
                end
                ST_WAIT_RSP: begin
                    if (cell_bus.cell_rsp_valid) begin
                        if (x_q == X_LAST) begin
                            x_q <= '0;
                            if (y_q == Y_LAST) begin
                                state_q <= ST_SWAP;
                            end else begin
                                y_q     <= y_q + 1'b1;
                                state_q <= ST_REQ;
                            end
                        end else begin
                            x_q     <= x_q + 1'b1;
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_SWAP: begin
                    bank_q  <= ~bank_q;
                    gen_q   <= gen_q + 1'b1;
                    state_q <= run ? ST_LATCH : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Status and request strobes are decodes of the state register; only the write strobe
    // follows the response input within the same cycle.
    assign busy                    = (state_q != ST_IDLE);
    assign update_done             = (state_q == ST_SWAP);
    assign cell_bus.cell_req_valid = (state_q == ST_REQ);
    assign cell_bus.cell_x         = x_q;
    assign cell_bus.cell_y         = y_q;
    assign cell_bus.wr_en          = rsp_accept;
    assign cell_bus.wr_data        = cell_bus.cell_next;
    assign cell_bus.wr_addr        = ADDR_W'(y_q) * ADDR_W'(GRID_W) + ADDR_W'(x_q);

    assign birth_mask   = masks_q.birth;
    assign survive_mask = masks_q.survive;
    assign bank_sel     = bank_q;
    assign gen_count    = gen_q;
    assign proto_err    = err_q;
endmodule
